// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and loads the IF/ID register.
// Handles stall, flush and branch redirects, and holds a branch that resolves during a stall.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_adel
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INST_SZ = 4;

  logic            ce_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_v, pend_v_d;
  logic [XLEN-1:0] pend_tgt, pend_tgt_d;
  logic [XLEN-1:0] if_pc_d, if_inst_d;
  logic            if_valid_d, if_adel_d;

  assign rom_ce   = ce_q;
  assign rom_addr = pc_q;

  // Next PC / pending redirect, then IF/ID capture; flush outranks stall in both.
  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v;
    pend_tgt_d = pend_tgt;
    if_pc_d    = if_pc;
    if_inst_d  = if_inst;
    if_valid_d = if_valid;
    if_adel_d  = if_adel;

    if (ce_q) begin
      if (flush) begin
        pc_d     = new_pc;
        pend_v_d = 1'b0;
      end else if (stall) begin
        if (branch_flag) begin
          pend_v_d   = 1'b1;
          pend_tgt_d = branch_target;
        end
      end else if (branch_flag) begin
        pc_d     = branch_target;
        pend_v_d = 1'b0;
      end else if (pend_v) begin
        pc_d     = pend_tgt;
        pend_v_d = 1'b0;
      end else begin
        pc_d = pc_q + XLEN'(INST_SZ);
      end
    end

    if (flush || (!stall && !ce_q)) begin
      if_pc_d    = '0;
      if_inst_d  = '0;
      if_valid_d = 1'b0;
      if_adel_d  = 1'b0;
    end else if (!stall) begin
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      // A misaligned fetch becomes a nop tagged with the address-error flag.
      if (pc_q[1:0] == 2'b00) begin
        if_inst_d = rom_inst;
        if_adel_d = 1'b0;
      end else begin
        if_inst_d = '0;
        if_adel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q     <= 1'b0;
      pc_q     <= RESET_PC;
      pend_v   <= 1'b0;
      pend_tgt <= '0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
      if_adel  <= 1'b0;
    end else begin
      ce_q     <= 1'b1;
      pc_q     <= pc_d;
      pend_v   <= pend_v_d;
      pend_tgt <= pend_tgt_d;
      if_pc    <= if_pc_d;
      if_inst  <= if_inst_d;
      if_valid <= if_valid_d;
      if_adel  <= if_adel_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural fetch model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch_flag;
  logic [31:0] new_pc, branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, if_adel;

  int n_vec = 0;
  int n_err = 0;

  // Model state: fetch PC, enable, pending redirect, IF/ID contents.
  logic [31:0] m_pc, m_pt, m_ipc, m_iinst;
  logic        m_ce, m_pv, m_iv, m_iadel;
  logic [31:0] nx_pc, nx_pt, nx_ipc, nx_iinst;
  logic        nx_pv, nx_iv, nx_iadel;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  // ROM: word i holds the value i.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  assign rom_inst = rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rom_ce",   32'(rom_ce),   32'(m_ce));
    chk("rom_addr", rom_addr,      m_pc);
    chk("if_pc",    if_pc,         m_ipc);
    chk("if_inst",  if_inst,       m_iinst);
    chk("if_valid", 32'(if_valid), 32'(m_iv));
    chk("if_adel",  32'(if_adel),  32'(m_iadel));
  endtask

  task automatic model_reset();
    m_ce = 1'b0; m_pc = 32'h0; m_pv = 1'b0; m_pt = 32'h0;
    m_ipc = 32'h0; m_iinst = 32'h0; m_iv = 1'b0; m_iadel = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, then compare.
  task automatic step(input logic s, input logic f, input logic [31:0] np,
                      input logic bf, input logic [31:0] bt);
    stall = s; flush = f; new_pc = np; branch_flag = bf; branch_target = bt;
    nx_pc = m_pc; nx_pv = m_pv; nx_pt = m_pt;
    if (m_ce) begin
      if (f)            begin nx_pc = np; nx_pv = 1'b0; end
      else if (s)       begin if (bf) begin nx_pv = 1'b1; nx_pt = bt; end end
      else if (bf)      begin nx_pc = bt; nx_pv = 1'b0; end
      else if (m_pv)    begin nx_pc = m_pt; nx_pv = 1'b0; end
      else              nx_pc = m_pc + 32'd4;
    end
    nx_ipc = m_ipc; nx_iinst = m_iinst; nx_iv = m_iv; nx_iadel = m_iadel;
    if (f || (!s && !m_ce)) begin
      nx_ipc = 0; nx_iinst = 0; nx_iv = 0; nx_iadel = 0;
    end else if (!s) begin
      nx_ipc = m_pc; nx_iv = 1'b1;
      nx_iadel = (m_pc % 4) != 0;
      nx_iinst = nx_iadel ? 32'h0 : rom_word(m_pc);
    end
    @(posedge clk);
    #1;
    m_ce = 1'b1; m_pc = nx_pc; m_pv = nx_pv; m_pt = nx_pt;
    m_ipc = nx_ipc; m_iinst = nx_iinst; m_iv = nx_iv; m_iadel = nx_iadel;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    stall = 0; flush = 0; new_pc = 0; branch_flag = 0; branch_target = 0; rst = 0;
    @(posedge clk);
    #1;
    do_reset();
    chk("cycle0_ce", 32'(rom_ce), 32'd0);

    idle();
    chk("cycle1_ce", 32'(rom_ce), 32'd1);
    chk("cycle1_addr", rom_addr, 32'h0);
    repeat (4) idle();
    chk("seq_addr", rom_addr, 32'h10);
    chk("seq_valid", 32'(if_valid), 32'd1);

    // Taken branch: the word at 0x10 is the delay slot and is kept.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    chk("br_if_pc", if_pc, 32'h10);
    chk("br_if_inst", if_inst, 32'h4);
    chk("br_addr", rom_addr, 32'h40);

    // Stall at 0x20 with a branch arriving mid-stall.
    step(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_hold_addr", rom_addr, 32'h20);
    idle();
    chk("rel_if_pc", if_pc, 32'h20);
    chk("rel_if_inst", if_inst, 32'h8);
    chk("rel_addr", rom_addr, 32'h80);

    // Flush during a stall discards the pending redirect.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
    step(1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
    chk("flush_addr", rom_addr, 32'h180);
    chk("flush_valid", 32'(if_valid), 32'd0);
    idle();
    chk("flush_nopend", rom_addr, 32'h184);

    // Misaligned branch target.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h42);
    idle();
    chk("adel_flag", 32'(if_adel), 32'd1);
    chk("adel_inst", if_inst, 32'h0);
    chk("adel_pc", if_pc, 32'h42);
    chk("adel_next", rom_addr, 32'h46);

    // PC wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    idle();
    chk("wrap_addr", rom_addr, 32'h0);

    // Reset mid-stall with a pending redirect.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    do_reset();
    chk("rst_ce", 32'(rom_ce), 32'd0);
    idle();
    idle();
    chk("rst_nopend", rom_addr, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bt, np;
      bt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 9) == 0) bt = bt | 32'($urandom_range(0, 3));
      np = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 15) == 0) np = 32'hFFFF_FFF8;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, np,
                $urandom_range(0, 4) == 0, bt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
